// File: rtl/flow_control_mc.sv
// Multi-channel FIFO occupancy tracker with hysteretic pause, sticky overflow
// flags and a round-robin pop arbiter shared by all channels.
module flow_control_mc #(
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       fifo_wr,
  input  logic                      pop_ready,
  output logic [CHANNELS-1:0]       pop_grant,
  output logic                      pop_valid,
  output logic [CHANNELS-1:0]       can_pop,
  output logic [CHANNELS-1:0]       pause,
  output logic [CHANNELS-1:0]       almost_full,
  output logic [CHANNELS-1:0]       almost_empty,
  output logic [CHANNELS-1:0]       fifo_full,
  output logic [CHANNELS-1:0]       fifo_empty,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic [CHANNELS-1:0]       err_overflow
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [CNT_W-1:0]    count_q [CHANNELS];
  logic [CNT_W-1:0]    count_d [CHANNELS];
  logic [CHANNELS-1:0] pause_q, pause_d;
  logic [CHANNELS-1:0] err_overflow_q, err_overflow_d;
  logic [CHANNELS-1:0] wr_acc;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    grant_idx;
  logic                grant_found;
  int                  arb_idx;

  // Flag decodes straight off the occupancy registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    can_pop      = '0;
    almost_full  = '0;
    almost_empty = '0;
    fifo_full    = '0;
    fifo_empty   = '0;
    count        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      can_pop[i]                 = (count_q[i] != '0);
      almost_full[i]             = (count_q[i] >= AF_C);
      almost_empty[i]            = (count_q[i] <= AE_C);
      fifo_full[i]               = (count_q[i] == DEPTH_C);
      fifo_empty[i]              = (count_q[i] == '0);
      count[i*CNT_W +: CNT_W]    = count_q[i];
    end
  end

  // Round-robin: first non-empty channel at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    arb_idx     = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      arb_idx = int'(rr_ptr_q) + k;
      if (arb_idx >= CHANNELS) arb_idx = arb_idx - CHANNELS;
      if (!grant_found && can_pop[arb_idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(arb_idx);
      end
    end
    pop_grant = '0;
    if (pop_ready && grant_found) pop_grant[grant_idx] = 1'b1;
    pop_valid = |pop_grant;
    rr_ptr_d  = rr_ptr_q;
    if (pop_valid) rr_ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
  end

  // A full channel still accepts a write when it is popped in the same cycle.
  always_comb begin
    wr_acc         = '0;
    count_d        = count_q;
    pause_d        = pause_q;
    err_overflow_d = err_overflow_q;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_acc[i]  = fifo_wr[i] && ((count_q[i] < DEPTH_C) || pop_grant[i]);
      count_d[i] = count_q[i] + CNT_W'(wr_acc[i]) - CNT_W'(pop_grant[i]);
      if (count_d[i] >= AF_C)      pause_d[i] = 1'b1;
      else if (count_d[i] <= AE_C) pause_d[i] = 1'b0;
      err_overflow_d[i] = err_overflow_q[i] | (fifo_wr[i] & ~wr_acc[i]);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the edge.
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) count_q[i] <= '0;
      pause_q        <= '0;
      err_overflow_q <= '0;
      rr_ptr_q       <= '0;
    end else begin
      count_q        <= count_d;
      pause_q        <= pause_d;
      err_overflow_q <= err_overflow_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign pause        = pause_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_flow_control_mc.sv
// Directed bench for flow_control_mc with default parameters: fill/pause,
// drain/hysteresis, overflow, round-robin order and mid-operation reset.
module tb_flow_control_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fifo_wr;
  logic        pop_ready;
  logic [3:0]  pop_grant, can_pop, pause, almost_full, almost_empty;
  logic [3:0]  fifo_full, fifo_empty, err_overflow;
  logic        pop_valid;
  logic [15:0] count;

  int pass_cnt = 0;
  int total_cnt = 0;

  flow_control_mc dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_wr      (fifo_wr),
    .pop_ready    (pop_ready),
    .pop_grant    (pop_grant),
    .pop_valid    (pop_valid),
    .can_pop      (can_pop),
    .pause        (pause),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .count        (count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] cnt(input int ch);
    return count[ch*4 +: 4];
  endfunction

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; fifo_wr = '0; pop_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (count !== 16'h0) $display("FAIL reset_count: got %h expected 0000", count); else pass_cnt++;
    total_cnt++; if (can_pop !== 4'b0000) $display("FAIL reset_can_pop: got %b expected 0000", can_pop); else pass_cnt++;
    total_cnt++; if (fifo_empty !== 4'b1111) $display("FAIL reset_empty: got %b expected 1111", fifo_empty); else pass_cnt++;
    total_cnt++; if (almost_empty !== 4'b1111) $display("FAIL reset_ae: got %b expected 1111", almost_empty); else pass_cnt++;
    total_cnt++; if (fifo_full !== 4'b0000 || almost_full !== 4'b0000)
      $display("FAIL reset_full_af: got %b/%b expected 0000/0000", fifo_full, almost_full); else pass_cnt++;
    total_cnt++; if (pop_grant !== 4'b0000 || pop_valid !== 1'b0)
      $display("FAIL reset_grant: got %b/%b expected 0000/0", pop_grant, pop_valid); else pass_cnt++;
    total_cnt++; if (pause !== 4'b0000 || err_overflow !== 4'b0000)
      $display("FAIL reset_pause_err: got %b/%b expected 0000/0000", pause, err_overflow); else pass_cnt++;
  endtask

  task automatic test_fill_pause();
    fifo_wr = 4'b0001; pop_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      total_cnt++; if (cnt(0) !== 4'(k)) $display("FAIL fill_count k=%0d: got %0d expected %0d", k, cnt(0), k); else pass_cnt++;
      total_cnt++; if (pause[0] !== (k >= 6)) $display("FAIL fill_pause k=%0d: got %b expected %b", k, pause[0], (k >= 6)); else pass_cnt++;
      total_cnt++; if (almost_full[0] !== (k >= 6)) $display("FAIL fill_af k=%0d: got %b expected %b", k, almost_full[0], (k >= 6)); else pass_cnt++;
    end
    fifo_wr = '0;
  endtask

  task automatic test_drain();
    logic exp_pause [6];
    exp_pause = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    pop_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      total_cnt++; if (pop_grant !== 4'b0001 || pop_valid !== 1'b1)
        $display("FAIL drain_grant k=%0d: got %b/%b expected 0001/1", k, pop_grant, pop_valid); else pass_cnt++;
      step();
      total_cnt++; if (cnt(0) !== 4'(5 - k)) $display("FAIL drain_count k=%0d: got %0d expected %0d", k, cnt(0), 5 - k); else pass_cnt++;
      total_cnt++; if (pause[0] !== exp_pause[k]) $display("FAIL drain_pause k=%0d: got %b expected %b", k, pause[0], exp_pause[k]); else pass_cnt++;
      total_cnt++; if (almost_empty[0] !== (5 - k <= 2)) $display("FAIL drain_ae k=%0d: got %b expected %b", k, almost_empty[0], (5 - k <= 2)); else pass_cnt++;
    end
    #1;
    total_cnt++; if (pop_grant !== 4'b0000 || pop_valid !== 1'b0)
      $display("FAIL drain_idle: got %b/%b expected 0000/0", pop_grant, pop_valid); else pass_cnt++;
    pop_ready = 1'b0;
  endtask

  task automatic test_overflow();
    fifo_wr = 4'b0010; pop_ready = 1'b0;
    for (int k = 0; k < 8; k++) step();
    total_cnt++; if (cnt(1) !== 4'd8 || fifo_full[1] !== 1'b1)
      $display("FAIL ovf_fill: got %0d/%b expected 8/1", cnt(1), fifo_full[1]); else pass_cnt++;
    total_cnt++; if (err_overflow !== 4'b0000) $display("FAIL ovf_no_err_yet: got %b expected 0000", err_overflow); else pass_cnt++;
    step();
    total_cnt++; if (cnt(1) !== 4'd8) $display("FAIL ovf_drop_count: got %0d expected 8", cnt(1)); else pass_cnt++;
    total_cnt++; if (err_overflow !== 4'b0010) $display("FAIL ovf_err_set: got %b expected 0010", err_overflow); else pass_cnt++;
    fifo_wr = '0;
    step();
    total_cnt++; if (err_overflow !== 4'b0010) $display("FAIL ovf_err_sticky: got %b expected 0010", err_overflow); else pass_cnt++;
    fifo_wr = 4'b0010; pop_ready = 1'b1;
    #1;
    total_cnt++; if (pop_grant !== 4'b0010) $display("FAIL ovf_pop_grant: got %b expected 0010", pop_grant); else pass_cnt++;
    step();
    total_cnt++; if (cnt(1) !== 4'd8) $display("FAIL ovf_wr_pop_count: got %0d expected 8", cnt(1)); else pass_cnt++;
    total_cnt++; if (err_overflow !== 4'b0010) $display("FAIL ovf_no_new_err: got %b expected 0010", err_overflow); else pass_cnt++;
    fifo_wr = '0;
    for (int k = 0; k < 8; k++) step();
    total_cnt++; if (cnt(1) !== 4'd0 || fifo_empty[1] !== 1'b1)
      $display("FAIL ovf_drained: got %0d/%b expected 0/1", cnt(1), fifo_empty[1]); else pass_cnt++;
    pop_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [6];
    exp_seq = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    do_reset();
    fifo_wr = 4'b1101; pop_ready = 1'b0;
    step();
    step();
    fifo_wr = '0;
    total_cnt++; if (count !== 16'h2202) $display("FAIL rr_setup: got %h expected 2202", count); else pass_cnt++;
    pop_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      total_cnt++; if (pop_grant !== exp_seq[k]) $display("FAIL rr_grant k=%0d: got %b expected %b", k, pop_grant, exp_seq[k]); else pass_cnt++;
      step();
    end
    #1;
    total_cnt++; if (pop_grant !== 4'b0000 || pop_valid !== 1'b0 || count !== 16'h0)
      $display("FAIL rr_done: got %b/%b/%h expected 0000/0/0000", pop_grant, pop_valid, count); else pass_cnt++;
    pop_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    fifo_wr = 4'b1000; pop_ready = 1'b0;
    for (int k = 0; k < 6; k++) step();
    fifo_wr = 4'b0000; pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
    total_cnt++; if (cnt(3) !== 4'd5 || pause[3] !== 1'b1)
      $display("FAIL mid_setup: got %0d/%b expected 5/1", cnt(3), pause[3]); else pass_cnt++;
    reset = 1'b0; fifo_wr = 4'b1000; pop_ready = 1'b1;
    step();
    reset = 1'b1; fifo_wr = '0; pop_ready = 1'b0;
    total_cnt++; if (cnt(3) !== 4'd0 || pause !== 4'b0000)
      $display("FAIL mid_count_pause: got %0d/%b expected 0/0000", cnt(3), pause); else pass_cnt++;
    total_cnt++; if (err_overflow !== 4'b0000 || can_pop !== 4'b0000)
      $display("FAIL mid_err_canpop: got %b/%b expected 0000/0000", err_overflow, can_pop); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0; fifo_wr = '0; pop_ready = 1'b0;
    test_reset();
    test_fill_pause();
    test_drain();
    test_overflow();
    test_round_robin();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/flow_control_mc.md
FLOW_CONTROL_MC -- requirements
Module: flow_control_mc

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent FIFO channels tracked.
REQ-002 Parameter DEPTH, default 8: capacity of each channel, in entries.
REQ-003 Parameter CNT_W, default 4: occupancy counter width; SHALL satisfy 2^CNT_W > DEPTH.
REQ-004 Parameter AF_THRESH, default 6: pause-set level; legal range AE_THRESH < AF_THRESH <= DEPTH.
REQ-005 Parameter AE_THRESH, default 2: pause-clear level; legal range 0 <= AE_THRESH < AF_THRESH.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 fifo_wr  in  CHANNELS  per-channel write strobe, one entry per asserted cycle.
REQ-009 pop_ready  in  1  downstream accepts one pop this cycle.
REQ-010 pop_grant  out  CHANNELS  one-hot pop select; all zero when no pop occurs.
REQ-011 pop_valid  out  1  OR of pop_grant.
REQ-012 can_pop  out  CHANNELS  bit i = (count[i] != 0).
REQ-013 pause  out  CHANNELS  per-channel hysteretic back-pressure to the writer.
REQ-014 almost_full / almost_empty  out  CHANNELS each  count >= AF_THRESH / count <= AE_THRESH.
REQ-015 fifo_full / fifo_empty  out  CHANNELS each  count == DEPTH / count == 0.
REQ-016 count  out  CHANNELS*CNT_W  flattened occupancy; channel i at bits [i*CNT_W +: CNT_W].
REQ-017 err_overflow  out  CHANNELS  sticky per-channel dropped-write flag.

Function
REQ-018 Each channel SHALL hold a registered occupancy counter; all flag outputs are combinational decodes of that register, with zero added latency.
REQ-019 Write acceptance: wr_acc[i] = fifo_wr[i] && (count[i] < DEPTH || pop_grant[i]).
REQ-020 Counter update per edge: count[i] <= count[i] + wr_acc[i] - pop_grant[i]; a simultaneous accepted write and pop leaves the count unchanged.
REQ-021 Write to a full channel with no pop that cycle: the write is dropped, count stays DEPTH, err_overflow[i] is set and held until reset.
REQ-022 pop_grant SHALL be combinational from registered state and pop_ready; all zero when pop_ready=0 or can_pop is all zero.
REQ-023 Arbitration: round-robin over the channels with can_pop=1, searching upward from rr_ptr (modulo CHANNELS); the first hit is granted.
REQ-024 rr_ptr (width ceil(log2 CHANNELS), minimum 1) SHALL update to (granted index + 1) mod CHANNELS on each edge with pop_valid=1, and hold otherwise.
REQ-025 An empty channel is never granted, so underflow is impossible by construction.
REQ-026 pause[i] register, evaluated from the next count value:
- set when next count >= AF_THRESH
- cleared when next count <= AE_THRESH
- held for AE_THRESH < next count < AF_THRESH
REQ-027 Consequence of REQ-026: pause changes in the same cycle the count crosses a threshold.
REQ-028 pause[i] is advisory; writes while paused are still accepted per REQ-019.
REQ-029 Channels SHALL be independent except for sharing the arbiter.

Reset
REQ-030 While reset=0 at a rising edge: all counts=0, pause=0, err_overflow=0, rr_ptr=0.
REQ-031 Outputs after reset: can_pop=0, fifo_empty=all 1, almost_empty=all 1, fifo_full=0, almost_full=0, pop_grant=0, pop_valid=0.
REQ-032 Reset SHALL override any write or pop in the same cycle.
REQ-033 Reset asserted mid-operation SHALL discard all occupancy, pause and error state.

Verification
REQ-034 Defaults used throughout; reset, then fifo_wr[0]=1 for 6 cycles with pop_ready=0 -> count0=6, pause[0]=1 and almost_full[0]=1 in the cycle count reaches 6.
REQ-035 From count0=6, pop_ready=1, no writes -> grants to channel 0 each cycle; pause[0] stays 1 at counts 5,4,3 and clears when count reaches 2.
REQ-036 Fill channel 1 to 8, then fifo_wr[1]=1 with pop_ready=0 -> count1 stays 8 and err_overflow[1]=1 persists; repeat with pop_ready=1 granting ch1 -> write accepted, count stays 8, no new error.
REQ-037 Channels 0,2,3 each at count 2, pop_ready=1 held -> grant sequence 0,2,3,0,2,3, then all zero; rr_ptr never selects empty channel 1.
REQ-038 Channel 3 at count 5 with pause=1, reset=0 for one cycle with fifo_wr[3]=1 -> count3=0, pause[3]=0, err_overflow=0, can_pop=0 on the next cycle.
